// File: rtl/ram.sv
// Word-organised behavioural test RAM: Avalon-MM slave plus a level-sensitive
// program port used to preload instructions while the CPU is held in reset.
// Each word is a ram_word instance; the top decodes, merges and muxes.

// One storage word. The program port lands in a transparent latch (zero-time,
// clock-independent), Avalon writes land in a flop, and an ownership bit says
// which copy is newest. A program-port hit asynchronously hands ownership back
// to the latch. That same clear also discards an Avalon write to this word in
// the same cycle.
module ram_word #(
    parameter int unsigned IDX_W = 6,
    parameter int unsigned IDX   = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             pg_en_i,
    input  logic [IDX_W-1:0] pg_idx_i,
    input  logic [31:0]      pg_data_i,
    input  logic             av_en_i,
    input  logic [IDX_W-1:0] av_idx_i,
    input  logic [31:0]      av_data_i,
    input  logic [3:0]       av_be_i,
    output logic [31:0]      word_o
);
    localparam logic [IDX_W-1:0] MY_IDX = IDX_W'(IDX);

    logic        pg_hit;
    logic        av_we;
    logic        own_clr;
    logic        own_av_q;
    logic [31:0] pg_q;
    logic [31:0] av_q;
    logic [31:0] av_d;

    assign pg_hit  = pg_en_i & (pg_idx_i == MY_IDX);
    assign av_we   = av_en_i & (av_idx_i == MY_IDX);
    assign own_clr = ~rst_ni | pg_hit;

    // Program-port copy: transparent while the port addresses this word.
    // The enable is decoded inside the latch so address and data are seen together.
    always_latch begin
        if (!rst_ni) begin
            pg_q = '0;
        end else if (pg_en_i && (pg_idx_i == MY_IDX)) begin
            pg_q = pg_data_i;
        end
    end

    // Ownership: set by a committed Avalon write, cleared at once by a program-port hit.
    always_ff @(posedge clk_i or posedge own_clr) begin
        if (own_clr) begin
            own_av_q <= 1'b0;
        end else if (av_we) begin
            own_av_q <= 1'b1;
        end
    end

    // Byte-lane merge of the Avalon write data into the currently visible word.
    always_comb begin
        av_d = word_o;
        for (int b = 0; b < 4; b++) begin
            if (av_be_i[b]) begin
                av_d[8*b +: 8] = av_data_i[8*b +: 8];
            end
        end
    end

    // Avalon copy: holds the merged word of the last committed write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            av_q <= '0;
        end else if (av_we && !pg_hit) begin
            av_q <= av_d;
        end
    end

    assign word_o = own_av_q ? av_q : pg_q;
endmodule

module ram #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        RAM_Reset,
    input  logic [31:0] address,
    input  logic        write,
    input  logic        read,
    output logic        waitrequest,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    input  logic [31:0] instruction,
    input  logic        inst_input,
    input  logic [7:0]  inst_addr
);
    // Word index is always address[7:2]; DEPTH_WORDS is expected to be 64 to match.
    localparam int unsigned AW = 6;

    logic [AW-1:0]                av_idx;
    logic [AW-1:0]                pg_idx;
    logic                         pg_en;
    logic                         stall;
    logic                         av_commit;
    logic                         rd_ok;
    logic [DEPTH_WORDS-1:0][31:0] words;
    logic                         unused_bits;

    assign av_idx      = address[7:2];
    assign pg_idx      = inst_addr[7:2];
    assign pg_en       = inst_input & RAM_Reset;
    // Byte offset and high address bits alias by design.
    assign unused_bits = ^{address[31:8], address[1:0], inst_addr[1:0]};

    generate
        if (WAIT_CYCLES == 0) begin : g_nowait
            assign stall = 1'b0;
        end else begin : g_wait
            localparam int unsigned CW = $clog2(WAIT_CYCLES + 1);
            localparam logic [CW-1:0] WC = CW'(WAIT_CYCLES);

            logic          req;
            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;

            assign req   = read | write;
            // Reset forces the stall low immediately, even with a request held.
            assign stall = RAM_Reset & req & (cnt_q < WC);

            // Count stalled edges; clear on completion or when the bus goes idle.
            always_comb begin
                cnt_d = '0;
                if (stall) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Wait-state counter register.
            always_ff @(posedge clk or negedge RAM_Reset) begin
                if (!RAM_Reset) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    assign waitrequest = stall;
    assign av_commit   = RAM_Reset & write & ~stall;
    assign rd_ok       = RAM_Reset & read & ~stall;

    for (genvar i = 0; i < DEPTH_WORDS; i++) begin : g_word
        ram_word #(
            .IDX_W (AW),
            .IDX   (i)
        ) u_word (
            .clk_i     (clk),
            .rst_ni    (RAM_Reset),
            .pg_en_i   (pg_en),
            .pg_idx_i  (pg_idx),
            .pg_data_i (instruction),
            .av_en_i   (av_commit),
            .av_idx_i  (av_idx),
            .av_data_i (writedata),
            .av_be_i   (byteenable),
            .word_o    (words[i])
        );
    end

    // Combinational read; the pre-write word is shown during a read+write cycle.
    assign readdata = rd_ok ? words[av_idx] : 32'h0;
endmodule

// File: tb/tb_ram.sv
// Bench for ram: a zero-wait instance and a two-wait-state instance share one
// bus; expected read data goes into a scoreboard queue when a read is issued
// and is popped when the data is sampled.
module tb_ram;
    logic        clk = 1'b0;
    logic        RAM_Reset;
    logic [31:0] address;
    logic        write;
    logic        read;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] instruction;
    logic        inst_input;
    logic [7:0]  inst_addr;
    logic        wr0, wr2;
    logic [31:0] rd0, rd2;

    int errors = 0;
    int checks = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    ram #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .RAM_Reset(RAM_Reset), .address(address), .write(write), .read(read),
        .waitrequest(wr0), .writedata(writedata), .byteenable(byteenable), .readdata(rd0),
        .instruction(instruction), .inst_input(inst_input), .inst_addr(inst_addr));

    ram #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .RAM_Reset(RAM_Reset), .address(address), .write(write), .read(read),
        .waitrequest(wr2), .writedata(writedata), .byteenable(byteenable), .readdata(rd2),
        .instruction(instruction), .inst_input(inst_input), .inst_addr(inst_addr));

    task automatic bus_idle();
        @(posedge clk); #1;
        read = 1'b0; write = 1'b0; byteenable = 4'h0;
    endtask

    task automatic av_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        @(posedge clk); #1;
        address = a; writedata = d; byteenable = be; write = 1'b1; read = 1'b0;
        @(posedge clk); #1;
        write = 1'b0; byteenable = 4'h0;
    endtask

    // Issue a read, record its expected data, and stop at the sampling edge.
    task automatic rd_start(input logic [31:0] a, input logic [31:0] e);
        @(posedge clk); #1;
        address = a; read = 1'b1; write = 1'b0;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic test_reset();
        RAM_Reset = 1'b0; read = 1'b1; write = 1'b0; address = 32'h0;
        writedata = 32'h0; byteenable = 4'h0;
        instruction = 32'h0; inst_input = 1'b0; inst_addr = 8'h0;
        #3;
        checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL reset_rd0: got %h expected %h", rd0, 32'h0); end
        checks++; if (wr0 !== 1'b0) begin errors++; $display("FAIL reset_wr0: got %b expected 0", wr0); end
        checks++; if (wr2 !== 1'b0) begin errors++; $display("FAIL reset_wr2: got %b expected 0", wr2); end
        checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL reset_rd2: got %h expected %h", rd2, 32'h0); end
        #7; RAM_Reset = 1'b1; read = 1'b0;
    endtask

    task automatic test_program_load();
        logic [7:0]  la[4] = '{8'h04, 8'h08, 8'h0C, 8'h10};
        logic [31:0] ld[4] = '{32'h24020010, 32'h24030020, 32'h00431021, 32'h00000008};
        logic [31:0] ra[6] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14};
        logic [31:0] re[6] = '{32'h0, 32'h24020010, 32'h24030020, 32'h00431021, 32'h00000008, 32'h0};
        logic [31:0] e;
        @(posedge clk); #1;
        inst_input = 1'b1;
        for (int i = 0; i < 4; i++) begin
            inst_addr = la[i]; instruction = ld[i]; #1;
        end
        inst_input = 1'b0; instruction = 32'hFFFFFFFF;
        for (int i = 0; i < 6; i++) begin
            rd_start(ra[i], re[i]);
            e = sb.pop_front();
            checks++; if (rd0 !== e) begin errors++; $display("FAIL load_read@%h: got %h expected %h", ra[i], rd0, e); end
            bus_idle();
        end
    endtask

    task automatic test_byte_enable();
        logic [31:0] e;
        av_write(32'h20, 32'hAABBCCDD, 4'b1111);
        av_write(32'h20, 32'h11223344, 4'b0101);
        rd_start(32'h20, 32'hAA22CC44);
        e = sb.pop_front();
        checks++; if (rd0 !== e) begin errors++; $display("FAIL byte_enable: got %h expected %h", rd0, e); end
        bus_idle();
        av_write(32'h20, 32'hFFFFFFFF, 4'b0000);
        rd_start(32'h20, 32'hAA22CC44);
        e = sb.pop_front();
        checks++; if (rd0 !== e) begin errors++; $display("FAIL be_zero: got %h expected %h", rd0, e); end
        bus_idle();
    endtask

    task automatic test_alias();
        logic [31:0] e;
        av_write(32'hBFC00024, 32'hDEADBEEF, 4'hF);
        rd_start(32'h00000024, 32'hDEADBEEF);
        e = sb.pop_front();
        checks++; if (rd0 !== e) begin errors++; $display("FAIL alias: got %h expected %h", rd0, e); end
        bus_idle();
        rd_start(32'h00000027, 32'hDEADBEEF);
        e = sb.pop_front();
        checks++; if (rd0 !== e) begin errors++; $display("FAIL misaligned: got %h expected %h", rd0, e); end
        bus_idle();
    endtask

    task automatic test_read_write_same();
        logic [31:0] e;
        av_write(32'h40, 32'h01020304, 4'hF);
        @(posedge clk); #1;
        address = 32'h40; read = 1'b1; write = 1'b1; writedata = 32'hA5A5A5A5; byteenable = 4'hF;
        sb.push_back(32'h01020304);
        @(negedge clk);
        e = sb.pop_front();
        checks++; if (rd0 !== e) begin errors++; $display("FAIL rw_prewrite: got %h expected %h", rd0, e); end
        @(posedge clk); #1;
        write = 1'b0; byteenable = 4'h0;
        sb.push_back(32'hA5A5A5A5);
        @(negedge clk);
        e = sb.pop_front();
        checks++; if (rd0 !== e) begin errors++; $display("FAIL rw_postwrite: got %h expected %h", rd0, e); end
        bus_idle();
    endtask

    task automatic test_prog_beats_avalon();
        logic [31:0] e;
        @(posedge clk); #1;
        address = 32'h30; writedata = 32'h12345678; byteenable = 4'hF; write = 1'b1;
        inst_addr = 8'h30; instruction = 32'hCAFEF00D; inst_input = 1'b1;
        @(posedge clk); #1;
        write = 1'b0; byteenable = 4'h0; inst_input = 1'b0;
        rd_start(32'h30, 32'hCAFEF00D);
        e = sb.pop_front();
        checks++; if (rd0 !== e) begin errors++; $display("FAIL prog_beats_av: got %h expected %h", rd0, e); end
        bus_idle();
        av_write(32'h30, 32'h11112222, 4'b0011);
        rd_start(32'h30, 32'hCAFE2222);
        e = sb.pop_front();
        checks++; if (rd0 !== e) begin errors++; $display("FAIL av_over_prog: got %h expected %h", rd0, e); end
        // Program-port write mid-cycle is visible before the next edge.
        #1; inst_addr = 8'h30; instruction = 32'h00000008; inst_input = 1'b1;
        #1; inst_input = 1'b0; sb.push_back(32'h00000008);
        e = sb.pop_front();
        checks++; if (rd0 !== e) begin errors++; $display("FAIL prog_over_av: got %h expected %h", rd0, e); end
        bus_idle();
    endtask

    task automatic test_wait_states();
        logic [31:0] e;
        int n;
        bus_idle();
        rd_start(32'h08, 32'h24030020);
        n = 0;
        while (wr2 === 1'b1 && n < 8) begin
            checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL wait_rd_zero: got %h expected %h", rd2, 32'h0); end
            n++;
            @(negedge clk);
        end
        checks++; if (n != 2) begin errors++; $display("FAIL wait_edges: got %0d expected 2", n); end
        e = sb.pop_front();
        checks++; if (rd2 !== e) begin errors++; $display("FAIL wait_data: got %h expected %h", rd2, e); end
        checks++; if (wr0 !== 1'b0) begin errors++; $display("FAIL nowait_wr0: got %b expected 0", wr0); end
        bus_idle();
    endtask

    task automatic test_reset_mid_transfer();
        logic [31:0] e;
        int n;
        bus_idle();
        @(posedge clk); #1;
        address = 32'h04; writedata = 32'h55555555; byteenable = 4'hF; write = 1'b1;
        @(posedge clk); #1;
        checks++; if (wr2 !== 1'b1) begin errors++; $display("FAIL pending_wr2: got %b expected 1", wr2); end
        #2; RAM_Reset = 1'b0; #1;
        checks++; if (wr2 !== 1'b0) begin errors++; $display("FAIL reset_drop_wr2: got %b expected 0", wr2); end
        @(posedge clk); #1;
        write = 1'b0; byteenable = 4'h0;
        #4; RAM_Reset = 1'b1;
        rd_start(32'h04, 32'h0);
        e = sb.pop_front();
        checks++; if (rd0 !== e) begin errors++; $display("FAIL post_reset_rd0: got %h expected %h", rd0, e); end
        sb.push_back(32'h0);
        n = 0;
        while (wr2 === 1'b1 && n < 8) begin
            n++;
            @(negedge clk);
        end
        checks++; if (n >= 8) begin errors++; $display("FAIL post_reset_timeout: got %0d stalled cycles expected 2", n); end
        e = sb.pop_front();
        checks++; if (rd2 !== e) begin errors++; $display("FAIL post_reset_rd2: got %h expected %h", rd2, e); end
        bus_idle();
    endtask

    initial begin
        test_reset();
        test_program_load();
        test_byte_enable();
        test_alias();
        test_read_write_same();
        test_prog_beats_avalon();
        test_wait_states();
        test_reset_mid_transfer();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
